// File: rtl/hevc_subpel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hevc_subpel_pkg
//  Description : Shared types, coefficient sets and width helpers for the
//                streaming vertical HEVC luma sub-pel interpolator.
//  Revision    : 1.0 - initial release
// ============================================================================
package hevc_subpel_pkg;

    // Block sequencing states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int TAPS      = 8;
    localparam int FILL_ROWS = 7;   // rows needed before the first full window
    localparam int OUT_W     = 16;  // signed output sample width

    // Eight signed 8-bit taps; element 0 applies to the oldest row
    typedef logic [TAPS-1:0][7:0] coef_set_t;

    // Quarter position: -1, 4, -10, 58, 17, -5, 1, 0
    localparam coef_set_t COEF_A = {8'h00, 8'h01, 8'hFB, 8'h11,
                                    8'h3A, 8'hF6, 8'h04, 8'hFF};
    // Half position: -1, 4, -11, 40, 40, -11, 4, -1
    localparam coef_set_t COEF_B = {8'hFF, 8'h04, 8'hF5, 8'h28,
                                    8'h28, 8'hF5, 8'h04, 8'hFF};
    // Three-quarter position: 0, 1, -5, 17, 58, -10, 4, -1
    localparam coef_set_t COEF_C = {8'hFF, 8'h04, 8'hF6, 8'h3A,
                                    8'h11, 8'hFB, 8'h01, 8'h00};

    // Accumulator width: sample bits plus headroom for the tap gain and sign
    function automatic int acc_width(input int bit_depth);
        return bit_depth + 8;
    endfunction

    // Right shift bringing the sum back to the 8-bit-normalised intermediate
    function automatic int out_shift(input int bit_depth);
        return bit_depth - 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hevc_vtap8.sv
`default_nettype none
// ============================================================================
//  Module      : hevc_vtap8
//  Description : Combinational 8-tap single-column filter. Unsigned samples,
//                signed taps, result shifted by (BIT_DEPTH-8) without rounding
//                and sign-extended or truncated to 16 bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module hevc_vtap8
    import hevc_subpel_pkg::*;
#(
    parameter int BIT_DEPTH = 8
) (
    input  logic [TAPS*BIT_DEPTH-1:0] samples,
    input  coef_set_t                 coef,
    output logic [OUT_W-1:0]          y
);

    localparam int ACC_W = acc_width(BIT_DEPTH);
    localparam int SHIFT = out_shift(BIT_DEPTH);

    logic signed [ACC_W-1:0] w_acc;
    logic signed [ACC_W-1:0] w_smp;
    logic signed [ACC_W-1:0] w_cf;
    logic signed [ACC_W-1:0] w_shifted;

    // Multiply-accumulate all eight taps at full accumulator precision
    always_comb begin
        w_acc = '0;
        w_smp = '0;
        w_cf  = '0;
        for (int t = 0; t < TAPS; t++) begin
            w_smp = ACC_W'($signed({1'b0, samples[t*BIT_DEPTH +: BIT_DEPTH]}));
            w_cf  = ACC_W'($signed(coef[t]));
            w_acc = w_acc + w_smp * w_cf;
        end
    end

    assign w_shifted = w_acc >>> SHIFT;
    assign y         = OUT_W'(w_shifted);

endmodule
`default_nettype wire

// File: rtl/hevc_vsubpel_stream.sv
`default_nettype none
// ============================================================================
//  Module      : hevc_vsubpel_stream
//  Description : Streaming vertical luma sub-pel interpolator. Requests
//                reference rows by index, keeps an 8-row sliding window and
//                emits quarter/half/three-quarter rows over valid/ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module hevc_vsubpel_stream
    import hevc_subpel_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int BIT_DEPTH = 8,
    parameter int ROWS      = 8,
    parameter int ROW_W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [2:0]               frac_mask,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH*BIT_DEPTH-1:0] in_row,
    output logic [ROW_W-1:0]         next_row,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH*OUT_W-1:0]   out_a,
    output logic [WIDTH*OUT_W-1:0]   out_b,
    output logic [WIDTH*OUT_W-1:0]   out_c,
    output logic [ROW_W-1:0]         out_row,
    output logic                     busy,
    output logic                     done
);

    localparam int ROW_BITS = WIDTH * BIT_DEPTH;
    localparam int OUT_BITS = WIDTH * OUT_W;

    localparam logic [ROW_W-1:0] LAST_IN   = ROW_W'(ROWS + 6);
    localparam logic [ROW_W-1:0] FILL_LAST = ROW_W'(FILL_ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_OFS   = ROW_W'(FILL_ROWS);

    state_t                state_q, state_d;
    logic [ROW_W-1:0]      cnt_q, cnt_d;
    logic [ROW_W-1:0]      out_row_q, out_row_d;
    logic [2:0]            mask_q, mask_d;
    logic                  out_valid_q, out_valid_d;
    logic [OUT_BITS-1:0]   out_a_q, out_a_d;
    logic [OUT_BITS-1:0]   out_b_q, out_b_d;
    logic [OUT_BITS-1:0]   out_c_q, out_c_d;
    logic [ROW_BITS-1:0]   win_q [TAPS];
    logic [ROW_BITS-1:0]   win_d [TAPS];

    logic [ROW_BITS-1:0]   w_win_next [TAPS];
    logic [OUT_BITS-1:0]   w_filt_a, w_filt_b, w_filt_c;
    logic                  w_in_ready, w_in_hs, w_out_hs;

    // Input acceptance: always while filling, only when the output slot frees up while running
    always_comb begin
        w_in_ready = 1'b0;
        case (state_q)
            ST_FILL: w_in_ready = 1'b1;
            ST_RUN:  w_in_ready = !out_valid_q || out_ready;
            default: w_in_ready = 1'b0;
        endcase
    end

    assign w_in_hs  = in_valid && w_in_ready;
    assign w_out_hs = out_valid_q && out_ready;

    // Window as it stands after shifting in the presented row; the filters
    // read this so the result can be registered on the accepting edge
    always_comb begin
        for (int t = 0; t < TAPS - 1; t++) begin
            w_win_next[t] = win_q[t+1];
        end
        w_win_next[TAPS-1] = in_row;
        for (int t = 0; t < TAPS; t++) begin
            win_d[t] = w_in_hs ? w_win_next[t] : win_q[t];
        end
    end

    // One column of three filters per pixel
    generate
        for (genvar p = 0; p < WIDTH; p++) begin : g_col
            logic [TAPS*BIT_DEPTH-1:0] w_col;
            for (genvar t = 0; t < TAPS; t++) begin : g_tap
                assign w_col[t*BIT_DEPTH +: BIT_DEPTH] = w_win_next[t][p*BIT_DEPTH +: BIT_DEPTH];
            end
            hevc_vtap8 #(.BIT_DEPTH(BIT_DEPTH)) u_tap_a (
                .samples (w_col),
                .coef    (COEF_A),
                .y       (w_filt_a[p*OUT_W +: OUT_W])
            );
            hevc_vtap8 #(.BIT_DEPTH(BIT_DEPTH)) u_tap_b (
                .samples (w_col),
                .coef    (COEF_B),
                .y       (w_filt_b[p*OUT_W +: OUT_W])
            );
            hevc_vtap8 #(.BIT_DEPTH(BIT_DEPTH)) u_tap_c (
                .samples (w_col),
                .coef    (COEF_C),
                .y       (w_filt_c[p*OUT_W +: OUT_W])
            );
        end
    endgenerate

    // Next-state, row counter and output-slot control
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mask_d      = mask_q;
        out_row_d   = out_row_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_c_d     = out_c_q;
        out_valid_d = out_valid_q && !w_out_hs;

        if (w_in_hs) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FILL;
                    mask_d  = frac_mask;
                    cnt_d   = '0;
                end
            end
            ST_FILL: begin
                if (w_in_hs && (cnt_q == FILL_LAST)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_in_hs) begin
                    out_valid_d = 1'b1;
                    out_row_d   = cnt_q - ROW_OFS;
                    out_a_d     = mask_q[0] ? w_filt_a : '0;
                    out_b_d     = mask_q[1] ? w_filt_b : '0;
                    out_c_d     = mask_q[2] ? w_filt_c : '0;
                    if (cnt_q == LAST_IN) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                if (w_out_hs) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters, output slot and window registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mask_q      <= '0;
            out_row_q   <= '0;
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_c_q     <= '0;
            for (int t = 0; t < TAPS; t++) begin
                win_q[t] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mask_q      <= mask_d;
            out_row_q   <= out_row_d;
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_c_q     <= out_c_d;
            for (int t = 0; t < TAPS; t++) begin
                win_q[t] <= win_d[t];
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign next_row  = cnt_q;
    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign out_c     = out_c_q;
    assign out_row   = out_row_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_hevc_vsubpel_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hevc_vsubpel_stream
//  Description : Self-checking bench for hevc_vsubpel_stream with a
//                direct-sum reference model of the vertical 8-tap filters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hevc_vsubpel_stream;

    localparam int WIDTH = 8;
    localparam int BD    = 8;
    localparam int ROWS  = 8;
    localparam int ROW_W = 8;
    localparam int NIN   = ROWS + 7;
    localparam int RB    = WIDTH * BD;
    localparam int OB    = WIDTH * 16;
    localparam int CW    = OB;

    logic              clk;
    logic              rst;
    logic              start;
    logic [2:0]        frac_mask;
    logic              in_valid;
    logic              in_ready;
    logic [RB-1:0]     in_row;
    logic [ROW_W-1:0]  next_row;
    logic              out_valid;
    logic              out_ready;
    logic [OB-1:0]     out_a, out_b, out_c;
    logic [ROW_W-1:0]  out_row;
    logic              busy;
    logic              done;

    hevc_vsubpel_stream #(
        .WIDTH(WIDTH), .BIT_DEPTH(BD), .ROWS(ROWS), .ROW_W(ROW_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .frac_mask(frac_mask),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .next_row(next_row), .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .out_row(out_row),
        .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Filter taps per position, oldest row first
    int taps [3][8] = '{'{-1, 4, -10, 58, 17, -5, 1, 0},
                        '{-1, 4, -11, 40, 40, -11, 4, -1},
                        '{ 0, 1, -5, 17, 58, -10, 4, -1}};

    int            img [NIN][WIDTH];
    logic [OB-1:0] got_a [ROWS];
    logic [OB-1:0] got_b [ROWS];
    logic [OB-1:0] got_c [ROWS];

    int n_vec = 0;
    int n_err = 0;

    int in_idx, out_idx, cyc, last_cyc, stall_cnt;
    bit done_seen, held;
    logic [OB-1:0]    held_a;
    logic [ROW_W-1:0] held_row;

    task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference output row k for one position: plain weighted sum of the
    // eight source rows, arithmetic shift, low 16 bits
    function automatic logic [OB-1:0] ref_row(input int k, input int pos, input logic [2:0] m);
        logic [OB-1:0] v;
        int s;
        v = '0;
        if (m[pos]) begin
            for (int p = 0; p < WIDTH; p++) begin
                s = 0;
                for (int t = 0; t < 8; t++) s += taps[pos][t] * img[k+t][p];
                s = s >>> (BD - 8);
                v[p*16 +: 16] = s[15:0];
            end
        end
        return v;
    endfunction

    task automatic drive_row();
        if (in_idx < NIN) begin
            for (int p = 0; p < WIDTH; p++) in_row[p*BD +: BD] = BD'(img[in_idx][p]);
        end else begin
            in_row = RB'({$urandom, $urandom});
        end
    endtask

    // mode 0: valid/ready held high; mode 1: random valid/ready plus a stray start
    task automatic run_block(input logic [2:0] m, input int mode, input int stall_row, input int abort_row);
        in_idx = 0; out_idx = 0; stall_cnt = 0; held = 0; done_seen = 0;
        @(negedge clk);
        chk("idle_busy", CW'(busy), CW'(0));
        chk("idle_next_row", CW'(next_row), CW'(0));
        start = 1'b1; frac_mask = m; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        frac_mask = 3'($urandom);
        chk("busy_after_start", CW'(busy), CW'(1));
        cyc = 0; last_cyc = 0;
        while (!done_seen && cyc < 2000) begin
            if (mode == 1) begin
                in_valid  = ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 3) != 0);
                start     = (cyc == 12);
            end else begin
                in_valid  = 1'b1;
                out_ready = 1'b1;
            end
            if (out_valid && out_idx == stall_row && stall_cnt < 5) begin
                out_ready = 1'b0;
                stall_cnt++;
            end
            drive_row();
            #1;
            if (abort_row >= 0 && out_valid && out_idx == abort_row) begin
                rst = 1'b1;
                #1;
                chk("abort_out_valid", CW'(out_valid), CW'(0));
                chk("abort_out_a", CW'(out_a), CW'(0));
                chk("abort_out_b", CW'(out_b), CW'(0));
                chk("abort_out_c", CW'(out_c), CW'(0));
                chk("abort_out_row", CW'(out_row), CW'(0));
                chk("abort_busy", CW'(busy), CW'(0));
                chk("abort_next_row", CW'(next_row), CW'(0));
                chk("abort_in_ready", CW'(in_ready), CW'(0));
                in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("abort_no_done", CW'(done), CW'(0));
                end
                rst = 1'b0;
                return;
            end
            chk("next_row", CW'(next_row), CW'(in_idx));
            if (held) begin
                chk("hold_valid", CW'(out_valid), CW'(1));
                chk("hold_out_a", CW'(out_a), CW'(held_a));
                chk("hold_out_row", CW'(out_row), CW'(held_row));
            end
            held = 0;
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", CW'(in_ready), CW'(0));
                held = 1; held_a = out_a; held_row = out_row;
            end
            if (in_valid && in_ready) in_idx++;
            if (out_valid && out_ready) begin
                chk("out_row", CW'(out_row), CW'(out_idx));
                if (out_idx < ROWS) begin
                    chk("out_a", CW'(out_a), CW'(ref_row(out_idx, 0, m)));
                    chk("out_b", CW'(out_b), CW'(ref_row(out_idx, 1, m)));
                    chk("out_c", CW'(out_c), CW'(ref_row(out_idx, 2, m)));
                    got_a[out_idx] = out_a; got_b[out_idx] = out_b; got_c[out_idx] = out_c;
                end
                if (mode == 0 && out_idx > 0)
                    chk("row_gap", CW'(cyc - last_cyc), CW'((out_idx == stall_row) ? 6 : 1));
                last_cyc = cyc;
                out_idx++;
            end
            if (done) begin
                chk("done_after_last_row", CW'(out_idx), CW'(ROWS));
                done_seen = 1;
            end
            cyc++;
            if (!done_seen) @(negedge clk);
        end
        if (!done_seen) chk("done_timeout", CW'(0), CW'(1));
        chk("rows_consumed", CW'(in_idx), CW'(NIN));
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("end_busy", CW'(busy), CW'(0));
        chk("end_done", CW'(done), CW'(0));
        chk("end_next_row", CW'(next_row), CW'(0));
    endtask

    task automatic fill_random();
        for (int r = 0; r < NIN; r++)
            for (int p = 0; p < WIDTH; p++) img[r][p] = int'($urandom_range(0, (1 << BD) - 1));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; frac_mask = '0; in_valid = 1'b0;
        out_ready = 1'b0; in_row = '0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid", CW'(out_valid), CW'(0));
        chk("rst_out_a", CW'(out_a), CW'(0));
        chk("rst_out_row", CW'(out_row), CW'(0));
        chk("rst_next_row", CW'(next_row), CW'(0));
        chk("rst_busy", CW'(busy), CW'(0));
        chk("rst_done", CW'(done), CW'(0));
        chk("rst_in_ready", CW'(in_ready), CW'(0));
        rst = 1'b0;

        // Flat image: 64 * 100 in every position
        for (int r = 0; r < NIN; r++)
            for (int p = 0; p < WIDTH; p++) img[r][p] = 100 << (BD - 8);
        run_block(3'b111, 0, -1, -1);
        chk("flat_a0", CW'(got_a[0][15:0]), CW'(6400));
        chk("flat_b_last", CW'(got_b[ROWS-1][OB-1 -: 16]), CW'(6400));
        chk("flat_c3", CW'(got_c[3][47:32]), CW'(6400));

        // Vertical step with a 5-cycle stall on output row 2
        for (int r = 0; r < NIN; r++)
            for (int p = 0; p < WIDTH; p++) img[r][p] = (r < 4) ? 0 : (64 << (BD - 8));
        run_block(3'b111, 0, 2, -1);
        chk("step_a0", CW'(got_a[0][15:0]), CW'(832));
        chk("step_b0", CW'(got_b[0][15:0]), CW'(2048));
        chk("step_c0", CW'(got_c[0][15:0]), CW'(3264));
        chk("step_a4", CW'(got_a[4][31:16]), CW'(4096));
        chk("step_c7", CW'(got_c[7][15:0]), CW'(4096));

        // Half position only; every third row bright gives alternating signs
        for (int r = 0; r < NIN; r++)
            for (int p = 0; p < WIDTH; p++) img[r][p] = (r % 3 == 2) ? 255 : 0;
        run_block(3'b010, 0, -1, -1);
        chk("neg_b0", CW'(got_b[0][15:0]), CW'(16'hEA16));   // -11*255*2 = -5610
        chk("neg_b1", CW'(got_b[1][15:0]), CW'(43 * 255));
        chk("mask_a0", CW'(got_a[0]), CW'(0));
        chk("mask_c0", CW'(got_c[0]), CW'(0));

        // Random images under random flow control
        fill_random();
        run_block(3'b010, 1, -1, -1);
        for (int i = 0; i < 3; i++) begin
            fill_random();
            run_block(3'($urandom_range(0, 7)), 1, -1, -1);
        end

        // Abort mid-run, then a clean block
        fill_random();
        run_block(3'b111, 0, -1, 3);
        fill_random();
        run_block(3'b111, 0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
